phase_unwrap_freq: RTL
======================

// Module: phase_unwrap_freq
// PURPOSE
//   Downstream stage of CalAngle; consumes its angle_o/val_o stream.
//   Computes the wrapped sample-to-sample phase difference (instantaneous frequency)
//   and the unwrapped, accumulated phase.
//   Also produces a block average of the frequency over 2^LOG2_AVG differences.
//   Angle format: two's complement binary angle, 0x8000 = -pi, 0x7FFF = +pi - 1 LSB.
// PARAMETERS
//   ANGLE_W   16  width of angle_i, freq_o and avg_o
//   ACC_W     32  width of the unwrapped phase accumulator phase_o (ACC_W >= ANGLE_W)
//   LOG2_AVG  4   average length = 2^LOG2_AVG frequency samples
// PORTS
//   clk        in   1         single clock; all logic on its rising edge
//   rst_i      in   1         reset; synchronous, active-high
//   val_i      in   1         angle_i valid this cycle
//   angle_i    in   ANGLE_W   wrapped angle from CalAngle
//   clr_i      in   1         synchronous restart of the unwrap and the averaging frame
//   phase_o    out  ACC_W     unwrapped phase (signed, wraps mod 2^ACC_W)
//   freq_o     out  ANGLE_W   signed phase difference (current minus previous angle)
//   val_o      out  1         phase_o/freq_o valid; 1-cycle pulse per accepted sample
//   avg_o      out  ANGLE_W   signed mean of the last completed 2^LOG2_AVG freq_o values
//   avg_val_o  out  1         avg_o updated; 1-cycle pulse
// BEHAVIOUR
//   Reset (rst_i=1): all outputs = 0; state = IDLE; prev angle, sum and count = 0.
//     rst_i overrides clr_i and val_i.
//     Mid-stream reset discards all history; the next sample is a first sample.
//   FSM states:
//     IDLE: no previous angle held.
//     RUN:  previous angle held.
//   IDLE with val_i=1:
//     phase_o = sign-extended angle_i; freq_o = 0; val_o = 1.
//     Go to RUN. Frame counter unchanged (this sample is not a difference).
//   RUN with val_i=1:
//     d = angle_i - prev, computed mod 2^ANGLE_W and taken as signed.
//     A difference of exactly 0x8000 is reported as -32768 (no saturation).
//     freq_o = d; phase_o = phase_o + sign-extended d, mod 2^ACC_W; val_o = 1.
//     Update prev with angle_i.
//   Averaging:
//     Each RUN difference is added to sum (width ANGLE_W+LOG2_AVG) and increments cnt.
//     When cnt reaches 2^LOG2_AVG-1 and a difference arrives:
//       avg_o = (sum + d) >>> LOG2_AVG (arithmetic shift, floor);
//       avg_val_o = 1 in the same cycle as that sample's val_o;
//       sum = 0; cnt = 0.
//   val_i=0: outputs hold; val_o = avg_val_o = 0. Gaps in val_i do not affect results.
//   clr_i=1: sum, cnt and the accumulator restart.
//     With val_i=0: state = IDLE.
//     With val_i=1: the sample is handled as an IDLE first sample in the same cycle.
//     avg_o holds its last value.
//   Latency: exactly 1 cycle from val_i to val_o. Throughput: 1 sample per cycle.
//   Arithmetic: all operations are two's complement; overflow wraps, never saturates.
// TESTING
//   T1 Reset: rst_i=1 for 3 cycles with val_i=1 and random angle_i
//      -> all outputs 0; val_o=0 throughout.
//   T2 Positive ramp: 40 samples, angle_i from 0x0000 in steps of +0x0400 (wraps at 0x8000)
//      -> freq_o=0x0400 from sample 2; phase_o=0x400*k, no wrap at +-pi;
//         avg_o=0x0400 with avg_val_o on samples 17 and 33.
//   T3 Negative crossing: angle_i 0x8100 then 0x7F00
//      -> freq_o=0xFE00 (-512); phase_o decreases by 512.
//   T4 Half-turn: angle_i 0x0000 then 0x8000 -> freq_o=0x8000; phase_o=0xFFFF8000.
//   T5 clr_i mid-frame: clr_i=1 with val_i=1, angle_i=0x1234 after 5 differences
//      -> phase_o=0x00001234, freq_o=0; next avg_val_o only after 16 further differences.
//   T6 Gapped stream: T2 stimulus with random val_i=0 gaps
//      -> val_o-qualified outputs identical to T2; each val_o exactly 1 cycle after its val_i.

Source files
------------

// File: rtl/phase_unwrap_freq.sv
// Phase unwrapper / instantaneous-frequency stage fed by the CalAngle angle stream.
// Latency: 1 cycle from val_i to val_o (and avg_val_o); one sample accepted per cycle.
// Backpressure: none; the block always accepts and val_i gaps simply hold the outputs.
//
// Ports:
//   clk, rst_i            single clock, synchronous active-high reset
//   val_i, angle_i        wrapped binary angle (0x8000 = -pi) and its valid strobe
//   clr_i                 restart unwrap and averaging frame (sample with it is a first sample)
//   phase_o               unwrapped accumulated phase, wraps mod 2^ACC_W
//   freq_o                signed wrapped difference current - previous angle
//   val_o                 1-cycle pulse per accepted sample
//   avg_o, avg_val_o      floor mean of the last 2^LOG2_AVG differences and its update pulse

module phase_unwrap_freq #(
    parameter int ANGLE_W  = 16,
    parameter int ACC_W    = 32,
    parameter int LOG2_AVG = 4
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               val_i,
    input  logic [ANGLE_W-1:0] angle_i,
    input  logic               clr_i,
    output logic [ACC_W-1:0]   phase_o,
    output logic [ANGLE_W-1:0] freq_o,
    output logic               val_o,
    output logic [ANGLE_W-1:0] avg_o,
    output logic               avg_val_o
);

    // The running sum needs LOG2_AVG guard bits so 2^LOG2_AVG full-scale
    // differences cannot overflow before the shift.
    localparam int SUM_W = ANGLE_W + LOG2_AVG;

    typedef enum logic {
        IDLE = 1'b0,   // no previous angle held
        RUN  = 1'b1    // previous angle held, next sample produces a difference
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ANGLE_W-1:0]  prev;
    logic [SUM_W-1:0]    sum;
    logic [LOG2_AVG-1:0] cnt;

    logic                take_first;
    logic                take_diff;
    logic                frame_done;
    logic [ANGLE_W-1:0]  diff;
    logic [ACC_W-1:0]    diff_acc;
    logic [SUM_W-1:0]    diff_sum;
    logic [SUM_W-1:0]    sum_tot;
    logic [ANGLE_W-1:0]  avg_nxt;
    logic [ACC_W-1:0]    first_phase;

    // ------------------------------------------------------------------
    // Sample classification
    // ------------------------------------------------------------------
    // clr_i forces the concurrent sample to be treated as a first sample,
    // regardless of whether a previous angle is held.
    always_comb begin
        take_first = val_i && (clr_i || (state == IDLE));
        take_diff  = val_i && !clr_i && (state == RUN);
    end

    // ------------------------------------------------------------------
    // Difference and averaging arithmetic
    // ------------------------------------------------------------------
    // The modular subtraction is exactly the wrapped phase step; the
    // half-turn (0x8000) naturally reads back as the most negative value.
    always_comb begin
        diff        = angle_i - prev;
        diff_acc    = ACC_W'($signed(diff));
        diff_sum    = SUM_W'($signed(diff));
        sum_tot     = sum + diff_sum;
        // Arithmetic shift gives a floor mean, not round-to-zero.
        avg_nxt     = ANGLE_W'($signed(sum_tot) >>> LOG2_AVG);
        first_phase = ACC_W'($signed(angle_i));
        frame_done  = (cnt == {LOG2_AVG{1'b1}});
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr_i && !val_i) begin
            state_nxt = IDLE;
        end else if (val_i) begin
            state_nxt = RUN;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_i) begin
            prev      <= '0;
            sum       <= '0;
            cnt       <= '0;
            phase_o   <= '0;
            freq_o    <= '0;
            val_o     <= 1'b0;
            avg_o     <= '0;
            avg_val_o <= 1'b0;
        end else begin
            val_o     <= take_first || take_diff;
            avg_val_o <= 1'b0;

            // A restart only drops the frame; avg_o keeps the last result.
            if (clr_i) begin
                sum <= '0;
                cnt <= '0;
            end

            if (take_first) begin
                phase_o <= first_phase;
                freq_o  <= '0;
                prev    <= angle_i;
            end

            if (take_diff) begin
                phase_o <= phase_o + diff_acc;
                freq_o  <= diff;
                prev    <= angle_i;
                if (frame_done) begin
                    avg_o     <= avg_nxt;
                    avg_val_o <= 1'b1;
                    sum       <= '0;
                    cnt       <= '0;
                end else begin
                    sum <= sum_tot;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
